// File: rtl/bounce_emu_cm_if.sv
// Handshake bundle for the contact-bounce emulator: the requesting side
// drives the clean target level and the bounce enable, and the emulator
// returns the noisy contact signal together with its settle status.
interface bounce_emu_cm_if;
   logic target;
   logic bounce_en;
   logic noisy_out;
   logic level;
   logic busy;
   logic done;

   modport master (
      output target,
      output bounce_en,
      input  noisy_out,
      input  level,
      input  busy,
      input  done
   );

   modport slave (
      input  target,
      input  bounce_en,
      output noisy_out,
      output level,
      output busy,
      output done
   );
endinterface

// File: rtl/bounce_emu_cm.sv
// Contact-bounce emulator.
// A free-running 16-bit Galois LFSR supplies the glitch count and the
// inter-toggle gaps. Each requested level change gives one edge to the new
// level, then G glitch pairs (away and back), then a fixed settle window.
// After the settle window the new level is published and done pulses once.
module bounce_emu_cm #(
   parameter int unsigned NSETTLE = 8,
   parameter int unsigned NBOUNCE = 6,
   parameter logic [3:0]  GAPMASK = 4'hF,
   parameter logic [15:0] SEED    = 16'hACE1
) (
   input logic            clk,
   input logic            reset,
   bounce_emu_cm_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BOUNCE = 2'b01,
      SETTLE = 2'b10
   } state_t;

   localparam logic [2:0] NBOUNCE_C = 3'(NBOUNCE);
   localparam logic [7:0] NSETTLE_C = 8'(NSETTLE);

   // One Galois step of x^16+x^14+x^13+x^11+1 (feedback mask 16'hB400).
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      logic [15:0] s;
      s = v >> 1;
      if (v[0]) begin
         s = s ^ 16'hB400;
      end else begin
         s = s;
      end
      return s;
   endfunction

   // Gap between successive toggles: 1 .. 16 cycles.
   function automatic logic [4:0] gap_len(input logic [15:0] v);
      return 5'd1 + {1'b0, v[3:0] & GAPMASK};
   endfunction

   // Glitch pair count, clamped to NBOUNCE and zero when bouncing is off.
   function automatic logic [2:0] glitch_cnt(input logic [15:0] v, input logic en);
      logic [2:0] g;
      if (!en) begin
         g = 3'd0;
      end else if (v[2:0] > NBOUNCE_C) begin
         g = NBOUNCE_C;
      end else begin
         g = v[2:0];
      end
      return g;
   endfunction

   state_t      state_r,      state_s;
   logic [15:0] lfsr_r;
   logic        new_r,        new_s;
   logic [2:0]  glitch_r,     glitch_s;
   logic        phase_r,      phase_s;
   logic [4:0]  gap_cnt_r,    gap_cnt_s;
   logic [7:0]  settle_cnt_r, settle_cnt_s;
   logic        noisy_r,      noisy_s;
   logic        level_r,      level_s;
   logic        busy_r,       busy_s;
   logic        done_r,       done_s;

   // Next-state and next-output decode of the IDLE/BOUNCE/SETTLE sequencer.
   always_comb begin
      state_s      = state_r;
      new_s        = new_r;
      glitch_s     = glitch_r;
      phase_s      = phase_r;
      gap_cnt_s    = gap_cnt_r;
      settle_cnt_s = settle_cnt_r;
      noisy_s      = noisy_r;
      level_s      = level_r;
      busy_s       = busy_r;
      done_s       = 1'b0;

      case (state_r)
         IDLE: begin
            noisy_s = level_r;
            if (bus.target != level_r) begin
               // First edge goes straight to the new level.
               new_s    = bus.target;
               noisy_s  = bus.target;
               busy_s   = 1'b1;
               phase_s  = 1'b0;
               glitch_s = glitch_cnt(lfsr_r, bus.bounce_en);
               if (glitch_s != 3'd0) begin
                  state_s      = BOUNCE;
                  gap_cnt_s    = gap_len(lfsr_r);
                  settle_cnt_s = 8'd0;
               end else begin
                  state_s      = SETTLE;
                  gap_cnt_s    = 5'd0;
                  settle_cnt_s = NSETTLE_C;
               end
            end else begin
               busy_s = 1'b0;
            end
         end

         BOUNCE: begin
            // A zero count is treated as expired so the counter never wraps.
            if (gap_cnt_r <= 5'd1) begin
               if (!phase_r) begin
                  noisy_s   = ~new_r;
                  phase_s   = 1'b1;
                  gap_cnt_s = gap_len(lfsr_r);
               end else begin
                  noisy_s  = new_r;
                  phase_s  = 1'b0;
                  glitch_s = glitch_r - 3'd1;
                  if (glitch_r <= 3'd1) begin
                     state_s      = SETTLE;
                     gap_cnt_s    = 5'd0;
                     settle_cnt_s = NSETTLE_C;
                  end else begin
                     gap_cnt_s = gap_len(lfsr_r);
                  end
               end
            end else begin
               gap_cnt_s = gap_cnt_r - 5'd1;
            end
         end

         SETTLE: begin
            if (settle_cnt_r <= 8'd1) begin
               level_s      = new_r;
               done_s       = 1'b1;
               busy_s       = 1'b0;
               settle_cnt_s = 8'd0;
               state_s      = IDLE;
            end else begin
               settle_cnt_s = settle_cnt_r - 8'd1;
            end
         end

         default: begin
            state_s = IDLE;
            busy_s  = 1'b0;
            noisy_s = level_r;
         end
      endcase
   end

   // State, LFSR and output registers; the LFSR advances every cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         lfsr_r       <= SEED;
         new_r        <= 1'b0;
         glitch_r     <= 3'd0;
         phase_r      <= 1'b0;
         gap_cnt_r    <= 5'd0;
         settle_cnt_r <= 8'd0;
         noisy_r      <= 1'b0;
         level_r      <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         lfsr_r       <= lfsr_step(lfsr_r);
         new_r        <= new_s;
         glitch_r     <= glitch_s;
         phase_r      <= phase_s;
         gap_cnt_r    <= gap_cnt_s;
         settle_cnt_r <= settle_cnt_s;
         noisy_r      <= noisy_s;
         level_r      <= level_s;
         busy_r       <= busy_s;
         done_r       <= done_s;
      end
   end

   assign bus.noisy_out = noisy_r;
   assign bus.level     = level_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;

endmodule

// File: tb/tb_bounce_emu_cm.sv
// Bench for the contact-bounce emulator: single-edge timing table, fast
// glitch bursts on a GAPMASK=0 instance, and reset abort/replay on the
// default instance against a schedule computed from the bench's own LFSR.
module tb_bounce_emu_cm;

   localparam int NS = 8;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   bounce_emu_cm_if a_if ();
   bounce_emu_cm_if z_if ();
   bounce_emu_cm_if f_if ();

   bounce_emu_cm u_a (.clk(clk), .reset(reset), .bus(a_if));
   bounce_emu_cm #(.NBOUNCE(0)) u_z (.clk(clk), .reset(reset), .bus(z_if));
   bounce_emu_cm #(.GAPMASK(4'h0), .NBOUNCE(7)) u_f (.clk(clk), .reset(reset), .bus(f_if));

   int total = 0;
   int bad   = 0;

   // Reference LFSR: x^16+x^14+x^13+x^11+1, seed 16'hACE1.
   function automatic logic [15:0] step16(input logic [15:0] v);
      logic [15:0] s;
      s = {1'b0, v[15:1]};
      if (v[0]) s = s ^ 16'hB400;
      return s;
   endfunction

   logic [15:0] lfsr_m;
   always @(posedge clk or negedge reset) begin
      if (!reset) lfsr_m <= 16'hACE1;
      else        lfsr_m <= step16(lfsr_m);
   end

   task automatic chk(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Expected per-cycle trace (index c = after edge k+c) for u_a.
   logic exp_n [0:255];
   logic exp_b [0:255];
   logic exp_d [0:255];
   logic exp_l [0:255];
   int   exp_len;

   task automatic build_exp(input logic [15:0] l0, input int g, input logic [3:0] gm, input logic nv);
      logic [15:0] lfa [0:255];
      int tog [0:15];
      int t, dt, n;
      lfa[0] = l0;
      for (int i = 1; i < 256; i++) lfa[i] = step16(lfa[i-1]);
      t = 0;
      tog[0] = 0;
      for (int p = 1; p <= 2*g; p++) begin
         t = t + 1 + int'(lfa[t][3:0] & gm);
         tog[p] = t;
      end
      dt = t + NS;
      exp_len = dt + 2;
      for (int c = 0; c < exp_len; c++) begin
         n = 0;
         for (int p = 0; p <= 2*g; p++) if (tog[p] <= c) n++;
         exp_n[c] = (n % 2 == 1) ? nv : ~nv;
         exp_b[c] = (c < dt);
         exp_d[c] = (c == dt);
         exp_l[c] = (c >= dt) ? nv : ~nv;
      end
   endtask

   // Compare u_a against the trace; bounce_en is dropped after the first
   // edge to show a running sequence ignores it.
   task automatic run_a(input int ncyc, input string tag);
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk); #1;
         chk($sformatf("%s c%0d noisy", tag, c), a_if.noisy_out, exp_n[c]);
         chk($sformatf("%s c%0d busy",  tag, c), a_if.busy,      exp_b[c]);
         chk($sformatf("%s c%0d done",  tag, c), a_if.done,      exp_d[c]);
         chk($sformatf("%s c%0d level", tag, c), a_if.level,     exp_l[c]);
         if (c == 0) a_if.bounce_en = 1'b0;
      end
   endtask

   typedef struct {
      logic t;
      logic n;
      logic l;
      logic b;
      logic d;
   } vec_t;

   vec_t tbl [0:19];

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      // target, noisy, level, busy, done (row i: input before edge, outputs after it)
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};   // edge k: start 0->1
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};   // target changes ignored
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 4; i <= 8; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};   // edge k+8: done
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};   // restart 1->0 after done
      for (int i = 11; i <= 17; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};   // target == level: stay idle

      a_if.target = 1'b0; a_if.bounce_en = 1'b0;
      z_if.target = 1'b0; z_if.bounce_en = 1'b1;
      f_if.target = 1'b0; f_if.bounce_en = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst noisy", a_if.noisy_out, 1'b0);
      chk("rst level", a_if.level,     1'b0);
      chk("rst busy",  a_if.busy,      1'b0);
      chk("rst done",  a_if.done,      1'b0);
      chk("rst f noisy", f_if.noisy_out, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      // Clean single edge on u_a (bounce_en=0) and u_z (NBOUNCE=0, bounce_en=1)
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         a_if.target = tbl[i].t;
         z_if.target = tbl[i].t;
         @(posedge clk); #1;
         chk($sformatf("tbl%0d a noisy", i), a_if.noisy_out, tbl[i].n);
         chk($sformatf("tbl%0d a level", i), a_if.level,     tbl[i].l);
         chk($sformatf("tbl%0d a busy",  i), a_if.busy,      tbl[i].b);
         chk($sformatf("tbl%0d a done",  i), a_if.done,      tbl[i].d);
         chk($sformatf("tbl%0d z noisy", i), z_if.noisy_out, tbl[i].n);
         chk($sformatf("tbl%0d z level", i), z_if.level,     tbl[i].l);
         chk($sformatf("tbl%0d z busy",  i), z_if.busy,      tbl[i].b);
         chk($sformatf("tbl%0d z done",  i), z_if.done,      tbl[i].d);
      end

      // Fast bursts on u_f: GAPMASK=0, NBOUNCE=7
      for (int tr = 0; tr < 20; tr++) begin
         logic [15:0] l0;
         logic        want, prev;
         int          g, cnt, first, last, dcyc;
         @(negedge clk);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         want = ~f_if.target;
         f_if.target = want;
         l0 = lfsr_m;
         g = int'(l0[2:0]);
         prev = f_if.noisy_out;
         cnt = 0; first = -1; last = -1; dcyc = -1;
         for (int c = 0; c < 100 && dcyc < 0; c++) begin
            @(posedge clk); #1;
            if (f_if.noisy_out !== prev) begin
               cnt++;
               if (first < 0) first = c;
               last = c;
               prev = f_if.noisy_out;
            end
            if (f_if.done === 1'b1) dcyc = c;
         end
         if (dcyc < 0) begin
            total++;
            bad++;
            $display("FAIL burst%0d timeout: got no done expected done within 100 cycles", tr);
         end else begin
            chk_int($sformatf("burst%0d toggles", tr), cnt, 2*g + 1);
            chk($sformatf("burst%0d odd_le15", tr), (cnt % 2 == 1) && (cnt <= 15), 1'b1);
            chk_int($sformatf("burst%0d first", tr), first, 0);
            chk_int($sformatf("burst%0d spacing", tr), last - first + 1, cnt);
            chk($sformatf("burst%0d final", tr), f_if.noisy_out, want);
            chk($sformatf("burst%0d level", tr), f_if.level, want);
            chk_int($sformatf("burst%0d settle", tr), dcyc - last, NS);
         end
      end

      // Reset abort during BOUNCE, then bit-exact replay on u_a
      @(negedge clk);
      reset = 1'b0;
      a_if.target = 1'b1;
      a_if.bounce_en = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      build_exp(lfsr_m, (lfsr_m[2:0] > 3'd6) ? 6 : int'(lfsr_m[2:0]), 4'hF, 1'b1);
      run_a(5, "run1");
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort noisy", a_if.noisy_out, 1'b0);
      chk("abort busy",  a_if.busy,      1'b0);
      chk("abort level", a_if.level,     1'b0);
      chk("abort done",  a_if.done,      1'b0);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         chk($sformatf("held%0d done", c),  a_if.done,      1'b0);
         chk($sformatf("held%0d noisy", c), a_if.noisy_out, 1'b0);
      end
      @(negedge clk);
      a_if.bounce_en = 1'b1;
      reset = 1'b1;
      build_exp(lfsr_m, (lfsr_m[2:0] > 3'd6) ? 6 : int'(lfsr_m[2:0]), 4'hF, 1'b1);
      run_a(exp_len, "run2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
